// File: rtl/block_reader_pkg.sv
// Shared types and constant helpers for the block raster reader.
package block_reader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    DATA     = 3'd2,
    BLK_WAIT = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [1:0] BURST_INCR = 2'b01;

  // Exact for the power-of-two sizes used here; usable in constant context.
  function automatic int unsigned clog2_u(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/block_addr_gen.sv
// Block/row position counters and the row, block and block-line address accumulators.
module block_addr_gen
  import block_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DIM_WIDTH       = 16,
  parameter int unsigned BLOCK_SIZE      = 8,
  parameter int unsigned BYTES_PER_PIXEL = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             i_load,
  input  logic                             i_next_row,
  input  logic                             i_next_block,
  input  logic [ADDR_WIDTH-1:0]            i_base_addr,
  input  logic [DIM_WIDTH-1:0]             i_frame_width,
  input  logic [DIM_WIDTH-1:0]             i_blocks_x,
  output logic [clog2_u(BLOCK_SIZE)-1:0]   o_row,
  output logic [DIM_WIDTH-1:0]             o_bx,
  output logic [DIM_WIDTH-1:0]             o_by,
  output logic [ADDR_WIDTH-1:0]            o_row_addr
);

  localparam int unsigned LOG_BS  = clog2_u(BLOCK_SIZE);
  localparam int unsigned LOG_BPP = clog2_u(BYTES_PER_PIXEL);
  localparam logic [ADDR_WIDTH-1:0] BLK_STEP = ADDR_WIDTH'(1) << (LOG_BS + LOG_BPP);

  logic [ADDR_WIDTH-1:0] r_stride;
  logic [ADDR_WIDTH-1:0] r_row_addr;
  logic [ADDR_WIDTH-1:0] r_block_addr;
  logic [ADDR_WIDTH-1:0] r_line_base;
  logic [ADDR_WIDTH-1:0] w_next_line;
  logic [LOG_BS-1:0]     r_row;
  logic [DIM_WIDTH-1:0]  r_bx;
  logic [DIM_WIDTH-1:0]  r_by;
  logic                  w_last_col;

  assign w_next_line = r_line_base + (r_stride << LOG_BS);
  assign w_last_col  = (r_bx == i_blocks_x - DIM_WIDTH'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stride     <= '0;
      r_row_addr   <= '0;
      r_block_addr <= '0;
      r_line_base  <= '0;
      r_row        <= '0;
      r_bx         <= '0;
      r_by         <= '0;
    end else if (i_load) begin
      r_stride     <= ADDR_WIDTH'(i_frame_width) << LOG_BPP;
      r_row_addr   <= i_base_addr;
      r_block_addr <= i_base_addr;
      r_line_base  <= i_base_addr;
      r_row        <= '0;
      r_bx         <= '0;
      r_by         <= '0;
    end else if (i_next_block) begin
      r_row <= '0;
      if (w_last_col) begin
        r_bx         <= '0;
        r_by         <= r_by + DIM_WIDTH'(1);
        r_line_base  <= w_next_line;
        r_block_addr <= w_next_line;
        r_row_addr   <= w_next_line;
      end else begin
        r_bx         <= r_bx + DIM_WIDTH'(1);
        r_block_addr <= r_block_addr + BLK_STEP;
        r_row_addr   <= r_block_addr + BLK_STEP;
      end
    end else if (i_next_row) begin
      r_row      <= r_row + LOG_BS'(1);
      r_row_addr <= r_row_addr + r_stride;
    end
  end

  assign o_row      = r_row;
  assign o_bx       = r_bx;
  assign o_by       = r_by;
  assign o_row_addr = r_row_addr;

endmodule

// File: rtl/block_raster_reader.sv
// Walks a frame in BLOCK_SIZE x BLOCK_SIZE blocks, one INCR burst per block row,
// and frames the returned beats for the Wiener filter.
module block_raster_reader
  import block_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH      = 32,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned BLOCK_SIZE      = 8,
  parameter int unsigned BYTES_PER_PIXEL = 4,
  parameter int unsigned DIM_WIDTH       = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIM_WIDTH-1:0]  frame_width,
  input  logic [DIM_WIDTH-1:0]  frame_height,
  input  logic [ADDR_WIDTH-1:0] base_addr_in,
  input  logic                  estimated_noise_ready,
  input  logic                  filter_ready,
  input  logic                  arready,
  input  logic                  rvalid,
  input  logic                  rlast,
  output logic                  start_read,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic [7:0]            read_len,
  output logic [2:0]            read_size,
  output logic [1:0]            read_burst,
  output logic                  filter_en,
  output logic                  start_data,
  output logic                  start_of_frame,
  output logic                  end_of_frame,
  output logic [31:0]           blocks_per_frame,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err
);

  localparam int unsigned LOG_BS  = clog2_u(BLOCK_SIZE);
  localparam int unsigned LOG_BPP = clog2_u(BYTES_PER_PIXEL);
  localparam int unsigned CW      = LOG_BS + 1;
  localparam logic [LOG_BS-1:0] LAST_ROW  = LOG_BS'(BLOCK_SIZE - 1);
  localparam logic [CW-1:0]     LAST_BEAT = CW'(BLOCK_SIZE - 1);
  localparam logic [1:0]        AR_LIMIT  = 2'd3;

  state_t                r_state;
  logic                  r_busy;
  logic                  r_err;
  logic                  r_ar_pend;
  logic [1:0]            r_ar_cnt;
  logic [CW-1:0]         r_beat_cnt;
  logic [DIM_WIDTH-1:0]  r_blocks_x;
  logic [DIM_WIDTH-1:0]  r_blocks_y;
  logic [31:0]           r_bpf;
  logic [ADDR_WIDTH-1:0] r_read_addr;

  logic                  w_load, w_check, w_zero, w_beat, w_last, w_row_end;
  logic                  w_last_blk, w_next_row, w_next_block, w_ar_timeout, w_err_set;
  logic [LOG_BS-1:0]     w_row;
  logic [DIM_WIDTH-1:0]  w_bx, w_by;
  logic [ADDR_WIDTH-1:0] w_row_addr;

  // Geometry is latched on the trigger; the zero-size check runs on the
  // following IDLE cycle (busy already set) from the latched block counts.
  assign w_load       = (r_state == IDLE) && !r_busy && estimated_noise_ready;
  assign w_check      = (r_state == IDLE) && r_busy;
  assign w_zero       = (r_blocks_x == '0) || (r_blocks_y == '0);
  assign w_beat       = (r_state == DATA) && rvalid;
  assign w_last       = w_beat && rlast;
  assign w_row_end    = (w_row == LAST_ROW);
  assign w_last_blk   = (w_bx == r_blocks_x - DIM_WIDTH'(1)) &&
                        (w_by == r_blocks_y - DIM_WIDTH'(1));
  assign w_next_row   = w_last && !w_row_end;
  assign w_next_block = (r_state == BLK_WAIT) && filter_ready;
  assign w_ar_timeout = r_ar_pend && !arready && (r_ar_cnt == AR_LIMIT);
  assign w_err_set    = (w_check && w_zero) ||
                        (w_last && (r_beat_cnt != LAST_BEAT)) ||
                        (rvalid && (r_state != DATA)) ||
                        w_ar_timeout;

  block_addr_gen #(
    .ADDR_WIDTH      (ADDR_WIDTH),
    .DIM_WIDTH       (DIM_WIDTH),
    .BLOCK_SIZE      (BLOCK_SIZE),
    .BYTES_PER_PIXEL (BYTES_PER_PIXEL)
  ) u_addr_gen (
    .clk           (clk),
    .rst           (rst),
    .i_load        (w_load),
    .i_next_row    (w_next_row),
    .i_next_block  (w_next_block),
    .i_base_addr   (base_addr_in),
    .i_frame_width (frame_width),
    .i_blocks_x    (r_blocks_x),
    .o_row         (w_row),
    .o_bx          (w_bx),
    .o_by          (w_by),
    .o_row_addr    (w_row_addr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_blocks_x  <= '0;
      r_blocks_y  <= '0;
      r_beat_cnt  <= '0;
      r_read_addr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_load) begin
            r_blocks_x <= frame_width >> LOG_BS;
            r_blocks_y <= frame_height >> LOG_BS;
            r_busy     <= 1'b1;
          end else if (w_check) begin
            r_state <= w_zero ? DONE : REQ;
          end
        end
        REQ: begin
          r_read_addr <= w_row_addr;
          r_beat_cnt  <= '0;
          r_state     <= DATA;
        end
        DATA: begin
          if (w_beat) r_beat_cnt <= r_beat_cnt + CW'(1);
          if (w_last) begin
            if (!w_row_end)     r_state <= REQ;
            else if (w_last_blk) r_state <= DONE;
            else                r_state <= BLK_WAIT;
          end
        end
        BLK_WAIT: if (filter_ready) r_state <= REQ;
        DONE: begin
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_err <= 1'b0;
    else if (w_load)    r_err <= 1'b0;
    else if (w_err_set) r_err <= 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_bpf <= '0;
    else     r_bpf <= 32'(r_blocks_x) * 32'(r_blocks_y);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ar_pend <= 1'b0;
      r_ar_cnt  <= '0;
    end else if (r_state == REQ) begin
      r_ar_pend <= !arready;
      r_ar_cnt  <= '0;
    end else if (r_ar_pend) begin
      if (arready || (r_ar_cnt == AR_LIMIT)) r_ar_pend <= 1'b0;
      else                                   r_ar_cnt  <= r_ar_cnt + 2'd1;
    end
  end

  assign start_read       = (r_state == REQ);
  assign read_addr        = (r_state == REQ) ? w_row_addr : r_read_addr;
  assign read_len         = 8'(BLOCK_SIZE - 1);
  assign read_size        = 3'(LOG_BPP);
  assign read_burst       = BURST_INCR;
  assign filter_en        = w_beat;
  assign start_data       = w_beat && (r_beat_cnt == '0) && (w_row == '0);
  assign start_of_frame   = start_data && (w_bx == '0) && (w_by == '0);
  assign end_of_frame     = w_last && w_row_end && w_last_blk;
  assign blocks_per_frame = r_bpf;
  assign busy             = r_busy;
  assign frame_done       = (r_state == DONE);
  assign err              = r_err;

endmodule

// File: tb/tb_block_raster_reader.sv
// Directed bench for block_raster_reader with a simple burst slave model.
module tb_block_raster_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] frame_width = '0;
  logic [15:0] frame_height = '0;
  logic [31:0] base_addr_in = '0;
  logic        estimated_noise_ready = 1'b0;
  logic        filter_ready = 1'b1;
  logic        arready = 1'b1;
  logic        rvalid = 1'b0;
  logic        rlast = 1'b0;

  logic        start_read, filter_en, start_data, start_of_frame, end_of_frame;
  logic        busy, frame_done, err;
  logic [31:0] read_addr, blocks_per_frame;
  logic [7:0]  read_len;
  logic [2:0]  read_size;
  logic [1:0]  read_burst;

  block_raster_reader #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BLOCK_SIZE(8), .BYTES_PER_PIXEL(4), .DIM_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .frame_width(frame_width), .frame_height(frame_height),
    .base_addr_in(base_addr_in), .estimated_noise_ready(estimated_noise_ready),
    .filter_ready(filter_ready), .arready(arready), .rvalid(rvalid), .rlast(rlast),
    .start_read(start_read), .read_addr(read_addr), .read_len(read_len),
    .read_size(read_size), .read_burst(read_burst), .filter_en(filter_en),
    .start_data(start_data), .start_of_frame(start_of_frame), .end_of_frame(end_of_frame),
    .blocks_per_frame(blocks_per_frame), .busy(busy), .frame_done(frame_done), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int trig_cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: samples DUT outputs on the falling edge.
  int          sr_cnt = 0, sd_cnt = 0, sof_cnt = 0, eof_cnt = 0, beats = 0;
  int          eof_beat = 0, fd_cnt = 0, fd_cyc = 0, sr_hold_cnt = 0;
  logic [31:0] addr_log [512];
  int          sr_cyc [512];

  always @(negedge clk) begin
    if (start_read) begin
      if (sr_cnt < 512) begin
        addr_log[sr_cnt] = read_addr;
        sr_cyc[sr_cnt]   = cyc;
      end
      sr_cnt++;
      if (!filter_ready) sr_hold_cnt++;
    end
    if (start_data) sd_cnt++;
    if (start_of_frame) sof_cnt++;
    if (filter_en) beats++;
    if (end_of_frame) begin
      eof_cnt++;
      eof_beat = beats;
    end
    if (frame_done) begin
      fd_cnt++;
      fd_cyc = cyc;
    end
  end

  // Slave: after each start_read returns sl_len beats, one per cycle.
  bit sl_active = 1'b0;
  int sl_cnt = 0, sl_len = 8, sl_burst = 0, hold_left = 0, last_beat_cyc = 0;
  bit hold_mode = 1'b0;
  int short_burst = -1;

  always @(posedge clk) begin
    #2;
    if (rst) begin
      sl_active = 1'b0;
      rvalid    = 1'b0;
      rlast     = 1'b0;
    end else begin
      if (hold_left > 0) begin
        hold_left--;
        if (hold_left == 0) filter_ready = 1'b1;
      end
      if (sl_active) begin
        if (sl_cnt < sl_len) begin
          rvalid = 1'b1;
          rlast  = (sl_cnt == sl_len - 1);
          sl_cnt++;
          if (rlast) begin
            last_beat_cyc = cyc;
            if (hold_mode && (sl_burst % 8 == 7)) begin
              hold_left    = 20;
              filter_ready = 1'b0;
            end
            sl_burst++;
          end
        end else begin
          rvalid    = 1'b0;
          rlast     = 1'b0;
          sl_active = 1'b0;
        end
      end
      if (start_read) begin
        sl_active = 1'b1;
        sl_cnt    = 0;
        sl_len    = (sl_burst == short_burst) ? 6 : 8;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic trigger(input logic [15:0] w, input logic [15:0] h, input logic [31:0] base);
    step();
    frame_width  = w;
    frame_height = h;
    base_addr_in = base;
    estimated_noise_ready = 1'b1;
    trig_cyc = cyc;
    step();
    estimated_noise_ready = 1'b0;
  endtask

  task automatic wait_done(input int fd0, output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if (fd_cnt != fd0) begin
        timed_out = 1'b0;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    step();
    step();
    checks++;
    if ({start_read, filter_en, start_data, start_of_frame, end_of_frame, busy, frame_done, err} !== 8'b0) begin
      errors++;
      $display("FAIL reset_flags got %b want 00000000",
               {start_read, filter_en, start_data, start_of_frame, end_of_frame, busy, frame_done, err});
    end
    checks++;
    if (read_addr !== 32'd0 || blocks_per_frame !== 32'd0) begin
      errors++;
      $display("FAIL reset_regs got addr=%0h bpf=%0d want 0 0", read_addr, blocks_per_frame);
    end
    checks++;
    if (read_len !== 8'd7 || read_size !== 3'd2 || read_burst !== 2'b01) begin
      errors++;
      $display("FAIL reset_consts got len=%0d size=%0d burst=%0d want 7 2 1", read_len, read_size, read_burst);
    end
    rst = 1'b0;
    step();
  endtask

  // Shared by the plain and back-pressure runs of the 16x16 frame.
  task automatic test_frame16(input bit hold, input int exp_gap);
    logic [31:0] b16 [4];
    logic [31:0] exp;
    int sr0, sd0, sof0, eof0, b0, fd0, h0;
    bit to;
    b16 = '{32'd0, 32'd32, 32'd512, 32'd544};
    hold_mode = hold;
    sr0 = sr_cnt; sd0 = sd_cnt; sof0 = sof_cnt; eof0 = eof_cnt; b0 = beats; fd0 = fd_cnt; h0 = sr_hold_cnt;
    trigger(16'd16, 16'd16, 32'd0);
    wait_done(fd0, to);
    checks++;
    if (to) begin errors++; $display("FAIL f16_done timeout got none want frame_done"); end
    checks++;
    if (fd_cyc - last_beat_cyc !== 1) begin
      errors++;
      $display("FAIL f16_done_lat got %0d want 1", fd_cyc - last_beat_cyc);
    end
    step();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL f16_idle got done=%b busy=%b want 0 0", frame_done, busy);
    end
    checks++;
    if (sr_cnt - sr0 !== 32) begin errors++; $display("FAIL f16_reads got %0d want 32", sr_cnt - sr0); end
    for (int i = 0; i < 32; i++) begin
      exp = b16[i / 8] + 32'((i % 8) * 64);
      checks++;
      if (addr_log[sr0 + i] !== exp) begin
        errors++;
        $display("FAIL f16_addr[%0d] got %0d want %0d", i, addr_log[sr0 + i], exp);
      end
    end
    checks++;
    if (sd_cnt - sd0 !== 4 || sof_cnt - sof0 !== 1 || eof_cnt - eof0 !== 1) begin
      errors++;
      $display("FAIL f16_strobes got sd=%0d sof=%0d eof=%0d want 4 1 1", sd_cnt - sd0, sof_cnt - sof0, eof_cnt - eof0);
    end
    checks++;
    if (eof_beat - b0 !== 256) begin errors++; $display("FAIL f16_eof_beat got %0d want 256", eof_beat - b0); end
    checks++;
    if (blocks_per_frame !== 32'd4) begin errors++; $display("FAIL f16_bpf got %0d want 4", blocks_per_frame); end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL f16_err got %b want 0", err); end
    checks++;
    if (sr_cyc[sr0 + 8] - sr_cyc[sr0 + 7] !== exp_gap) begin
      errors++;
      $display("FAIL f16_blk_gap got %0d want %0d", sr_cyc[sr0 + 8] - sr_cyc[sr0 + 7], exp_gap);
    end
    checks++;
    if (sr_hold_cnt - h0 !== 0) begin
      errors++;
      $display("FAIL f16_read_in_hold got %0d want 0", sr_hold_cnt - h0);
    end
    hold_mode = 1'b0;
    for (int i = 0; i < 25; i++) step();
  endtask

  task automatic test_remainder();
    int sr0, fd0;
    bit to;
    sr0 = sr_cnt; fd0 = fd_cnt;
    trigger(16'd20, 16'd12, 32'h1000);
    wait_done(fd0, to);
    checks++;
    if (to) begin errors++; $display("FAIL rem_done timeout got none want frame_done"); end
    step();
    checks++;
    if (blocks_per_frame !== 32'd2) begin errors++; $display("FAIL rem_bpf got %0d want 2", blocks_per_frame); end
    checks++;
    if (sr_cnt - sr0 !== 16) begin errors++; $display("FAIL rem_reads got %0d want 16", sr_cnt - sr0); end
    checks++;
    if (addr_log[sr0] !== 32'h1000 || addr_log[sr0 + 1] !== 32'h1050) begin
      errors++;
      $display("FAIL rem_stride got %0h,%0h want 1000,1050", addr_log[sr0], addr_log[sr0 + 1]);
    end
    checks++;
    if (addr_log[sr0 + 8] !== 32'h1020 || addr_log[sr0 + 15] !== 32'h1250) begin
      errors++;
      $display("FAIL rem_blk1 got %0h,%0h want 1020,1250", addr_log[sr0 + 8], addr_log[sr0 + 15]);
    end
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL rem_err got %b want 0", err); end
  endtask

  task automatic test_zero_blocks();
    int sr0, fd0;
    bit to;
    sr0 = sr_cnt; fd0 = fd_cnt;
    trigger(16'd4, 16'd16, 32'd0);
    wait_done(fd0, to);
    checks++;
    if (to) begin errors++; $display("FAIL zero_done timeout got none want frame_done"); end
    checks++;
    if (fd_cyc - trig_cyc !== 2) begin errors++; $display("FAIL zero_done_lat got %0d want 2", fd_cyc - trig_cyc); end
    step();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL zero_err got %b want 1", err); end
    checks++;
    if (sr_cnt - sr0 !== 0) begin errors++; $display("FAIL zero_reads got %0d want 0", sr_cnt - sr0); end
    checks++;
    if (busy !== 1'b0 || blocks_per_frame !== 32'd0) begin
      errors++;
      $display("FAIL zero_state got busy=%b bpf=%0d want 0 0", busy, blocks_per_frame);
    end
  endtask

  task automatic test_short_burst();
    int sr0, fd0;
    bit to;
    sr0 = sr_cnt; fd0 = fd_cnt;
    short_burst = sl_burst + 3;
    trigger(16'd16, 16'd16, 32'd0);
    wait_done(fd0, to);
    short_burst = -1;
    checks++;
    if (to) begin errors++; $display("FAIL short_done timeout got none want frame_done"); end
    step();
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", err); end
    checks++;
    if (sr_cnt - sr0 !== 32) begin errors++; $display("FAIL short_reads got %0d want 32", sr_cnt - sr0); end
    fd0 = fd_cnt;
    trigger(16'd16, 16'd16, 32'd0);
    checks++;
    if (err !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL short_retrigger got err=%b busy=%b want 0 1", err, busy);
    end
    wait_done(fd0, to);
    step();
    checks++;
    if (to || err !== 1'b0) begin
      errors++;
      $display("FAIL short_clean got timeout=%b err=%b want 0 0", to, err);
    end
  endtask

  task automatic test_reset_mid_frame();
    int sr0, sr_at, sof0, fd0;
    bit to;
    sr0 = sr_cnt;
    trigger(16'd16, 16'd16, 32'd0);
    to = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      if (sr_cnt - sr0 >= 17) begin to = 1'b0; break; end
      step();
    end
    checks++;
    if (to) begin errors++; $display("FAIL rstmid_reach timeout got %0d reads want 17", sr_cnt - sr0); end
    step();
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({start_read, filter_en, start_data, start_of_frame, end_of_frame, busy, frame_done, err} !== 8'b0) begin
      errors++;
      $display("FAIL rstmid_flags got %b want 00000000",
               {start_read, filter_en, start_data, start_of_frame, end_of_frame, busy, frame_done, err});
    end
    checks++;
    if (read_addr !== 32'd0 || blocks_per_frame !== 32'd0) begin
      errors++;
      $display("FAIL rstmid_regs got addr=%0h bpf=%0d want 0 0", read_addr, blocks_per_frame);
    end
    sr_at = sr_cnt;
    step(); step(); step();
    rst = 1'b0;
    step(); step();
    checks++;
    if (sr_cnt !== sr_at) begin errors++; $display("FAIL rstmid_no_read got %0d want %0d", sr_cnt, sr_at); end
    sr0 = sr_cnt; sof0 = sof_cnt; fd0 = fd_cnt;
    trigger(16'd16, 16'd16, 32'd0);
    wait_done(fd0, to);
    step();
    checks++;
    if (to) begin errors++; $display("FAIL rstmid_restart timeout got none want frame_done"); end
    checks++;
    if (addr_log[sr0] !== 32'd0 || sr_cnt - sr0 !== 32) begin
      errors++;
      $display("FAIL rstmid_restart_addr got addr=%0h reads=%0d want 0 32", addr_log[sr0], sr_cnt - sr0);
    end
    checks++;
    if (sof_cnt - sof0 !== 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_restart_sof got sof=%0d err=%b want 1 0", sof_cnt - sof0, err);
    end
  endtask

  initial begin
    test_reset();
    test_frame16(1'b0, 10);
    test_frame16(1'b1, 29);
    test_remainder();
    test_zero_blocks();
    test_short_burst();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/block_raster_reader.md
Name: block_raster_reader

Overview:
- Reads one frame from the AXI frame buffer in BLOCK_SIZE x BLOCK_SIZE raster-block order and drives the burst read master and the Wiener filter.
- For each block row it issues one INCR burst request through the master's start_read interface.
- It counts returned beats and generates filter framing strobes (filter_en, start_data, start_of_frame, end_of_frame) in hardware, so a bench does not have to gate the filter clock manually.
- Geometry, block size and pixel size are parametrised. The block also adds filter back-pressure and error reporting.

Parameters:
- ADDR_WIDTH, 32, address width.
- DATA_WIDTH, 32, AXI data width; one pixel per beat.
- BLOCK_SIZE, 8, block edge in pixels; must be a power of 2, 2..64.
- BYTES_PER_PIXEL, 4, address stride per pixel; must be a power of 2.
- DIM_WIDTH, 16, width of the frame_width and frame_height inputs.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- frame_width  in  DIM_WIDTH  pixels per line
- frame_height  in  DIM_WIDTH  lines per frame
- base_addr_in  in  ADDR_WIDTH  frame base byte address
- estimated_noise_ready  in  1  frame start trigger (single-cycle pulse)
- filter_ready  in  1  filter can accept the next block
- arready  in  1  AXI read-address ready (monitored)
- rvalid  in  1  AXI read-data valid
- rlast  in  1  AXI last beat
- start_read  out  1  one-cycle burst request to the master
- read_addr  out  ADDR_WIDTH  burst start byte address
- read_len  out  8  burst length in AXI arlen encoding, fixed at BLOCK_SIZE-1
- read_size  out  3  log2(BYTES_PER_PIXEL)
- read_burst  out  2  fixed 2'b01 (INCR)
- filter_en  out  1  beat-valid qualifier for the filter
- start_data  out  1  first beat of each block
- start_of_frame  out  1  first beat of block 0
- end_of_frame  out  1  last beat of the last block
- blocks_per_frame  out  32  blocks_x*blocks_y for the current frame
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle completion pulse
- err  out  1  sticky error flag; cleared at the next frame start

Behaviour:
- Reset: every output is 0 except read_len, read_size and read_burst, which are constants. The FSM goes to IDLE and all counters and addresses clear.
- Reset mid-frame aborts the frame immediately. No further start_read is issued.
- States: IDLE, REQ, DATA, BLK_WAIT, DONE.
- IDLE:
  - On estimated_noise_ready, latch the geometry and base address, clear err, and set busy.
  - blocks_x = frame_width>>log2(BLOCK_SIZE); blocks_y likewise from frame_height. Remainder pixels are skipped.
  - blocks_per_frame is registered on the following cycle.
  - If blocks_x or blocks_y is 0, set err and go to DONE. Otherwise go to REQ.
  - estimated_noise_ready while busy is ignored.
- REQ:
  - start_read = 1 for exactly one cycle, with read_addr valid and held stable until the next REQ.
  - Next state is DATA.
- DATA:
  - filter_en = rvalid, combinational. Each beat with rvalid=1 increments beat_cnt.
  - start_data = rvalid at beat 0 of row 0.
  - start_of_frame = start_data for block 0.
  - On rvalid&rlast:
    - If beat_cnt != BLOCK_SIZE-1, set err. The FSM proceeds as normal.
    - If row < BLOCK_SIZE-1: row++, row_addr += frame_width*BYTES_PER_PIXEL, go to REQ.
    - Else, on the last block: end_of_frame = 1 on that beat, go to DONE.
    - Else go to BLK_WAIT.
- BLK_WAIT:
  - Stay until filter_ready = 1.
  - Then advance the block:
    - Normally bx++ and block_addr += BLOCK_SIZE*BYTES_PER_PIXEL.
    - At bx = blocks_x-1: bx = 0, by++, line_base += BLOCK_SIZE*frame_width*BYTES_PER_PIXEL, block_addr = line_base.
  - Set row = 0, row_addr = block_addr, and go to REQ.
- DONE: frame_done = 1 for one cycle, busy is cleared, next state is IDLE.
- Address arithmetic:
  - All adds are modulo 2^ADDR_WIDTH; no overflow detection.
  - Multiplications by BLOCK_SIZE and BYTES_PER_PIXEL are implemented as shifts.
  - frame_width*BYTES_PER_PIXEL is computed once, at latch.
- arready is monitored only. If arready is still 0 four cycles after start_read, set err. No retry is attempted.
- A beat with rvalid=1 outside DATA is ignored and sets err.

Decomposition:
- Package block_reader_pkg holds:
  - state_t enum (IDLE, REQ, DATA, BLK_WAIT, DONE)
  - BURST_INCR = 2'b01
  - localparam functions for clog2 of BLOCK_SIZE and BYTES_PER_PIXEL
- Sub-module block_addr_gen holds the bx/by/row counters and the three address accumulators, with inputs next_row, next_block and load.
- The top level holds the FSM and beat framing.

Test Plan:
- 16x16 frame, BS=8, BPP=4, base 0, with a slave model returning 8-beat bursts and filter_ready tied to 1.
  - read_addr sequence: block 0 = 0,64,...,448; block 1 = 32,96,...,480; block 2 = 512..960 step 64; block 3 = 544..992.
  - 32 start_read pulses, 4 start_data pulses, 1 start_of_frame, 1 end_of_frame on beat 256.
  - blocks_per_frame = 4; frame_done 1 cycle after the final rlast.
- Same frame with filter_ready held low for 20 cycles after each block: BLK_WAIT holds, no start_read during the hold, address sequence unchanged.
- 20x12 frame, base 0x1000: blocks_per_frame = 2; second block first address 0x1020; row stride 80 bytes; err = 0.
- 4x16 frame: err = 1, frame_done pulse 2 cycles after the trigger, no start_read.
- Slave returns rlast on the 6th beat of row 3: err = 1, the frame still completes, and the next trigger clears err.
- rst asserted during block 2 DATA: all outputs are 0 on the next edge; a new trigger restarts at base with start_of_frame asserted.
